// File: rtl/fifo_burst_reader.sv
// Read-side burst master for sync_fifo: pulls a counted burst out of the FIFO
// and streams it downstream on valid/ready. The FIFO's one-cycle read latency
// is absorbed by a two-entry holding buffer.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  abort,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned OCC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  req_cnt, req_cnt_nxt;
  logic [LEN_WIDTH-1:0]  out_cnt, out_cnt_nxt;
  logic [DATA_WIDTH-1:0] tail, tail_nxt, head_nxt;
  logic [1:0]            buf_cnt, buf_cnt_nxt;
  logic                  inflight;
  logic                  done_nxt;
  logic                  pop;
  logic                  abort_hit;
  logic                  flush;
  logic [OCC_W-1:0]      occ;

  // Handshake and read-issue decode; occupancy counts the word still in flight
  always_comb begin
    pop        = out_valid && out_ready;
    occ        = OCC_W'(buf_cnt) + OCC_W'(inflight) - OCC_W'(pop);
    fifo_rd_en = !rst && (state == ST_READ) && !fifo_empty &&
                 (req_cnt != '0) && (occ < OCC_W'(2));
    abort_hit  = abort && ((state == ST_READ) || (state == ST_DRAIN));
  end

  // Next-state, counter and holding-buffer logic
  always_comb begin
    state_nxt   = state;
    req_cnt_nxt = req_cnt;
    out_cnt_nxt = out_cnt;
    done_nxt    = 1'b0;
    head_nxt    = out_data;
    tail_nxt    = tail;
    buf_cnt_nxt = buf_cnt;
    flush       = 1'b0;

    if (fifo_rd_en) begin
      req_cnt_nxt = req_cnt - LEN_WIDTH'(1);
    end
    if (pop && (out_cnt != '0)) begin
      out_cnt_nxt = out_cnt - LEN_WIDTH'(1);
    end

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            req_cnt_nxt = burst_len;
            out_cnt_nxt = burst_len;
            state_nxt   = ST_READ;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (abort_hit) begin
          state_nxt = ST_FLUSH;
          flush     = 1'b1;
        end else if (fifo_rd_en && (req_cnt == LEN_WIDTH'(1))) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort_hit) begin
          state_nxt = ST_FLUSH;
          flush     = 1'b1;
        end else if (pop && (out_cnt == LEN_WIDTH'(1))) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush       = 1'b1;
        state_nxt   = ST_IDLE;
        done_nxt    = 1'b1;
        req_cnt_nxt = '0;
        out_cnt_nxt = '0;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Buffer update: pop shifts tail to head, capture lands behind any survivor
    if (flush) begin
      buf_cnt_nxt = 2'd0;
    end else begin
      unique case ({pop, inflight})
        2'b10: begin
          head_nxt    = tail;
          buf_cnt_nxt = buf_cnt - 2'd1;
        end
        2'b01: begin
          if (buf_cnt == 2'd0) head_nxt = fifo_data;
          else                 tail_nxt = fifo_data;
          buf_cnt_nxt = buf_cnt + 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            head_nxt = fifo_data;
          end else begin
            head_nxt = tail;
            tail_nxt = fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters, buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_cnt   <= '0;
      out_cnt   <= '0;
      buf_cnt   <= 2'd0;
      inflight  <= 1'b0;
      out_data  <= '0;
      tail      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_cnt   <= req_cnt_nxt;
      out_cnt   <= out_cnt_nxt;
      buf_cnt   <= buf_cnt_nxt;
      inflight  <= fifo_rd_en;
      out_data  <= head_nxt;
      tail      <= tail_nxt;
      out_valid <= (buf_cnt_nxt != 2'd0);
      out_last  <= (buf_cnt_nxt != 2'd0) && (out_cnt_nxt == LEN_WIDTH'(1));
      busy      <= (state_nxt != ST_IDLE);
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural sync FIFO model upstream,
// expected-word scoreboard downstream, directed burst scenarios.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] burst_len;
  logic       abort;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .abort      (abort),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  // Upstream sync FIFO model: data appears the cycle after an accepted read
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] fcnt;
  logic       wr_en, fifo_clr;
  logic [7:0] wr_data;

  assign fifo_empty = (fcnt == 5'd0);

  always @(posedge clk) begin
    if (fifo_clr) begin
      wp <= 4'd0; rp <= 4'd0; fcnt <= 5'd0; fifo_data <= 8'd0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + 4'd1;
      end
      if (fifo_rd_en && fcnt != 5'd0) begin
        fifo_data <= mem[rp];
        rp <= rp + 4'd1;
      end
      fcnt <= fcnt + 5'(wr_en) - 5'(fifo_rd_en && fcnt != 5'd0);
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  logic [8:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops, read legality, done pulse width, backpressure stability
  logic       p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_done = 1'b0;
  logic       p_rst = 1'b0, p_abort = 1'b0;
  logic [7:0] p_data = 8'd0;
  always @(negedge clk) begin
    logic [8:0] e;
    if (fifo_rd_en) rd_cnt++;
    if (fifo_empty) chk("rd_en_while_empty", 32'(fifo_rd_en), 32'd0);
    if (done) begin
      done_cnt++;
      chk("done_one_cycle", 32'(p_done), 32'd0);
    end
    if (p_valid && !p_ready && !p_rst && !p_abort) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(p_data));
      chk("hold_last", 32'(out_last), 32'(p_last));
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(out_data), 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e[7:0]));
        chk("out_last", 32'(out_last), 32'(e[8]));
      end
    end
    p_valid = out_valid; p_ready = out_ready; p_last = out_last;
    p_data = out_data; p_done = done; p_rst = rst; p_abort = abort;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fifo(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic expect_burst(input logic [7:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == last_at), 8'(base + 8'(i))});
  endtask

  task automatic wait_done(input int max, input bit tgl, input string name);
    bit got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      @(posedge clk); #1;
      if (tgl) out_ready = !out_ready;
    end
    chk(name, 32'(got), 32'd1);
    tick();
  endtask

  task automatic clear_fifo();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask

  initial begin
    int rd0, dn0;
    rst = 1'b1; fifo_clr = 1'b1; start = 1'b0; burst_len = 8'd0; abort = 1'b0;
    out_ready = 1'b1; wr_en = 1'b0; wr_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    tick();
    rst = 1'b0; fifo_clr = 1'b0;
    tick();

    // 1: back-to-back burst of 4, first word two edges after START
    for (int i = 0; i < 4; i++) push_fifo(8'(10 * (i + 1)));
    exp_q.push_back({1'b0, 8'd10}); exp_q.push_back({1'b0, 8'd20});
    exp_q.push_back({1'b0, 8'd30}); exp_q.push_back({1'b1, 8'd40});
    start = 1'b1; burst_len = 8'd4;
    tick();
    start = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("t1_first_valid", 32'(out_valid), 32'd1);
    chk("t1_first_data", 32'(out_data), 32'd10);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("t1_stream_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_valid_after", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_done_low", 32'(done), 32'd0);
    chk("t1_fifo_empty", 32'(fcnt), 32'd0);
    tick();

    // 2: burst of 8 with toggling ready
    for (int i = 0; i < 8; i++) push_fifo(8'(8'hA0 + 8'(i)));
    expect_burst(8'hA0, 8, 7);
    rd0 = rd_cnt; dn0 = done_cnt;
    start = 1'b1; burst_len = 8'd8;
    tick();
    start = 1'b0;
    wait_done(200, 1'b1, "t2_done_seen");
    out_ready = 1'b1;
    chk("t2_reads", 32'(rd_cnt - rd0), 32'd8);
    chk("t2_fifo_empty", 32'(fcnt), 32'd0);
    chk("t2_words_left", 32'(exp_q.size()), 32'd0);

    // 3: FIFO runs dry mid-burst, refilled later
    push_fifo(8'h31);
    expect_burst(8'h31, 3, 2);
    rd0 = rd_cnt;
    start = 1'b1; burst_len = 8'd3;
    tick();
    start = 1'b0;
    repeat (5) tick();
    push_fifo(8'h32);
    push_fifo(8'h33);
    wait_done(40, 1'b0, "t3_done_seen");
    chk("t3_reads", 32'(rd_cnt - rd0), 32'd3);
    chk("t3_words_left", 32'(exp_q.size()), 32'd0);

    // 4: zero-length burst
    rd0 = rd_cnt; dn0 = done_cnt;
    start = 1'b1; burst_len = 8'd0;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    chk("t4_done_low", 32'(done), 32'd0);
    chk("t4_busy_low", 32'(busy), 32'd0);
    chk("t4_reads", 32'(rd_cnt - rd0), 32'd0);
    chk("t4_done_count", 32'(done_cnt - dn0), 32'd1);
    tick();

    // 5: abort after two pops
    for (int i = 0; i < 5; i++) push_fifo(8'(8'hB0 + 8'(i)));
    expect_burst(8'hB0, 2, 9);
    rd0 = rd_cnt;
    start = 1'b1; burst_len = 8'd5;
    tick();
    start = 1'b0;
    repeat (4) tick();
    out_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t5_valid_dropped", 32'(out_valid), 32'd0);
    chk("t5_no_early_done", 32'(done), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_reads", 32'(rd_cnt - rd0), 32'd4);
    chk("t5_fifo_left", 32'(fcnt), 32'd1);
    chk("t5_words_left", 32'(exp_q.size()), 32'd0);
    tick();
    clear_fifo();

    // 6: reset mid-burst, then START while busy is ignored
    for (int i = 0; i < 8; i++) push_fifo(8'(8'hC0 + 8'(i)));
    out_ready = 1'b0;
    start = 1'b1; burst_len = 8'd8;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_last", 32'(out_last), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t6_data", 32'(out_data), 32'd0);
    tick();
    clear_fifo();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_fifo(8'(8'hD0 + 8'(i)));
    expect_burst(8'hD0, 3, 2);
    rd0 = rd_cnt; dn0 = done_cnt;
    start = 1'b1; burst_len = 8'd3;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; burst_len = 8'd7;
    tick();
    start = 1'b0;
    wait_done(40, 1'b0, "t6_done_seen");
    repeat (3) tick();
    chk("t6_reads", 32'(rd_cnt - rd0), 32'd3);
    chk("t6_fifo_left", 32'(fcnt), 32'd2);
    chk("t6_done_count", 32'(done_cnt - dn0), 32'd1);
    chk("t6_busy_idle", 32'(busy), 32'd0);
    chk("t6_words_left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
